// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Shared op encodings, FSM state codes, iteration constants and
//               a magnitude helper for the MIPS multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int ITER_COUNT = 32;
  localparam int LATENCY    = 33;

  // Two's-complement magnitude; unsigned ops pass the value through.
  function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_iter_step.sv
// ============================================================================
// Module      : mdu_iter_step
// Description : One combinational iteration: shift-add multiply step or
//               restoring-divide step on unsigned magnitudes. The divide path
//               exists only when MULT_DIV_UNIT_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
`ifdef MULT_DIV_UNIT_DIV_EN
  input  logic             div_mode,
`endif
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] w_sum;

  // Multiply: acc_hi is the partial product, acc_lo the remaining multiplier bits.
  assign w_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);

`ifdef MULT_DIV_UNIT_DIV_EN
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  assign w_shifted = {acc_hi, acc_lo[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, operand};
  assign w_fits    = ~w_diff[WIDTH];

  always_comb begin
    if (div_mode) begin
      nxt_hi = w_fits ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], w_fits};
    end else begin
      nxt_hi = w_sum[WIDTH:1];
      nxt_lo = {w_sum[0], acc_lo[WIDTH-1:1]};
    end
  end
`else
  assign nxt_hi = w_sum[WIDTH:1];
  assign nxt_lo = {w_sum[0], acc_lo[WIDTH-1:1]};
`endif

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers.
//               Divide support is built only with MULT_DIV_UNIT_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]       r_state;
  logic [4:0]       r_count;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_operand;
  logic             r_neg_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_idle;
  logic             w_start_ok;
  logic             w_signed;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH-1:0] w_nxt_hi;
  logic [WIDTH-1:0] w_nxt_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_idle   = (r_state == IDLE);
  assign w_signed = ~op[0];
  assign w_mag1   = mdu_abs(data1, w_signed);
  assign w_mag2   = mdu_abs(data2, w_signed);

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_lo ? (~w_prod + 1'b1) : w_prod;

`ifdef MULT_DIV_UNIT_DIV_EN
  logic             r_is_div;
  logic             r_neg_hi;
  logic             r_dz;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_start_ok = start & w_idle;

  // A zero divisor yields an all-ones quotient; the remainder path already
  // reproduces the dividend, so only LO needs forcing.
  assign w_quo = r_dz ? '1 : (r_neg_lo ? (~r_acc_lo + 1'b1) : r_acc_lo);
  assign w_rem = r_neg_hi ? (~r_acc_hi + 1'b1) : r_acc_hi;

  assign w_res_hi = r_is_div ? w_rem : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_is_div ? w_quo : w_prod_fix[WIDTH-1:0];

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (r_is_div),
    .acc_hi   (r_acc_hi),
    .acc_lo   (r_acc_lo),
    .operand  (r_operand),
    .nxt_hi   (w_nxt_hi),
    .nxt_lo   (w_nxt_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
    end else if (w_start_ok) begin
      r_is_div <= op[1];
      r_neg_hi <= w_signed & data1[WIDTH-1];
      r_dz     <= (data2 == '0);
    end
  end
`else
  // Divide ops are dropped outright in a multiply-only build.
  assign w_start_ok = start & w_idle & ~op[1];

  assign w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_res_lo = w_prod_fix[WIDTH-1:0];

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc_hi   (r_acc_hi),
    .acc_lo   (r_acc_lo),
    .operand  (r_operand),
    .nxt_hi   (w_nxt_hi),
    .nxt_lo   (w_nxt_lo)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_operand <= '0;
      r_neg_lo  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (wr_hi) r_hi <= data1;
          if (wr_lo) r_lo <= data1;
          if (w_start_ok) begin
            r_acc_hi <= '0;
            // Divide streams the dividend through acc_lo; multiply streams the multiplier.
            if (op[1]) begin
              r_acc_lo  <= w_mag1;
              r_operand <= w_mag2;
            end else begin
              r_acc_lo  <= w_mag2;
              r_operand <= w_mag1;
            end
            r_neg_lo <= w_signed & (data1[WIDTH-1] ^ data2[WIDTH-1]);
            r_count  <= 5'(ITER_COUNT - 1);
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_acc_hi <= w_nxt_hi;
          r_acc_lo <= w_nxt_lo;
          r_count  <= r_count - 5'd1;
          if (r_count == 5'd0) r_state <= FIX;
        end
        FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = ~w_idle;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit; divide
//               expectations follow MULT_DIV_UNIT_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        wr_hi;
  logic        wr_lo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .data1 (data1),
    .data2 (data2),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge: drives start immediately, then watches for done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int limit, output int lat, output int bcnt, output bit got);
    int k;
    start = 1'b1; op = o; data1 = a; data2 = b;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    bcnt = 0;
    while (k < limit && !done) begin
      if (busy) bcnt++;
      @(negedge clk);
      k++;
    end
    got = done;
    lat = k - 1;
  endtask

  initial begin : main
    int  lat;
    int  bcnt;
    int  ndone;
    bit  got;

    reset = 1'b1; start = 1'b0; op = 2'b00; data1 = '0; data2 = '0;
    wr_hi = 1'b0; wr_lo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b0;
    @(negedge clk);

    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 60, lat, bcnt, got);
    check("multu_done", got, 1);
    check("multu_latency", lat, 33);
    check("multu_busy_cycles", bcnt, 33);
    check("multu_busy_at_done", busy, 0);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    // Back-to-back: launched in the done cycle of the previous op.
    do_op(2'b00, 32'hFFFFFFFD, 32'd5, 60, lat, bcnt, got);
    check("mult_b2b_latency", lat, 33);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFF1);
    @(negedge clk);
    check("done_one_cycle", done, 0);

`ifdef MULT_DIV_UNIT_DIV_EN
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 60, lat, bcnt, got);
    check("div_latency", lat, 33);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    do_op(2'b10, 32'd7, 32'hFFFFFFFE, 60, lat, bcnt, got);
    check("div_negdivisor_lo", lo, 32'hFFFFFFFD);
    check("div_negdivisor_hi", hi, 32'd1);
    do_op(2'b11, 32'd100, 32'd0, 60, lat, bcnt, got);
    check("divu_dz_lo", lo, 32'hFFFFFFFF);
    check("divu_dz_hi", hi, 32'd100);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 60, lat, bcnt, got);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'h00000000);
    do_op(2'b11, 32'd1000, 32'd7, 60, lat, bcnt, got);
    check("divu_lo", lo, 32'd142);
    check("divu_hi", hi, 32'd6);
`else
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 40, lat, bcnt, got);
    check("div_dropped_done", got, 0);
    check("div_dropped_busy", bcnt, 0);
    check("div_dropped_hi", hi, 32'hFFFFFFFF);
    check("div_dropped_lo", lo, 32'hFFFFFFF1);
`endif

    // MTHI / MTLO while idle.
    wr_hi = 1'b1; data1 = 32'h12345678;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi", hi, 32'h12345678);
    wr_lo = 1'b1; data1 = 32'h0BADF00D;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mtlo", lo, 32'h0BADF00D);

    // MTLO and a second start while busy must both be ignored.
    start = 1'b1; op = 2'b01; data1 = 32'd3; data2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    lat = 0;
    for (int k = 1; k < 80; k++) begin
      wr_lo = (k == 3);
      if (k == 3) data1 = 32'hDEADBEEF;
      start = (k == 6);
      if (k == 6) begin op = 2'b00; data1 = 32'd100; data2 = 32'd100; end
      if (k == 5) check("lo_stable_busy", lo, 32'h0BADF00D);
      if (k == 5) check("hi_stable_busy", hi, 32'h12345678);
      if (done) begin ndone++; if (lat == 0) lat = k - 1; end
      @(negedge clk);
    end
    wr_lo = 1'b0; start = 1'b0;
    check("ignored_start_dones", ndone, 1);
    check("ignored_start_latency", lat, 33);
    check("busy_mtlo_lo", lo, 32'd12);
    check("busy_mtlo_hi", hi, 32'd0);

    // Reset mid-operation discards the op.
    start = 1'b1; op = 2'b01; data1 = 32'd5; data2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k < 60; k++) begin
      reset = (k == 11);
      if (k == 12) begin
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
      end
      if (done) ndone++;
      @(negedge clk);
    end
    reset = 1'b0;
    check("midrst_no_done", ndone, 0);

    do_op(2'b01, 32'd7, 32'd6, 60, lat, bcnt, got);
    check("post_rst_done", got, 1);
    check("post_rst_lo", lo, 32'd42);
    check("post_rst_hi", hi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
